// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file write-port controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int NREG   = 1 << REG_AW;

    // A write request to the register file at the default data width.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wr;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

    // Which source owns the write port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_BUF  = 2'd2,
        GNT_MDIR = 2'd3
    } gnt_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard: registers still owed a result by the multi-cycle unit.
// Latency: set/clear land at the next edge; stall is combinational from state and inputs.
// Backpressure: raises stall_o to hold decode; never blocks a clear.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid_i,
    input  logic [REG_AW-1:0] iss_rd_i,
    input  logic              clr_valid_i,
    input  logic [REG_AW-1:0] clr_rd_i,
    input  logic [REG_AW-1:0] chk_rs1_i,
    input  logic [REG_AW-1:0] chk_rs2_i,
    output logic              stall_o,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // Next busy vector: clear first so a same-register set wins; x0 never pends.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid_i) set_mask[iss_rd_i] = 1'b1;
        if (clr_valid_i) clr_mask[clr_rd_i] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Busy state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    // The issue term blocks a second writer being issued to a pending register.
    assign stall_o = rst & (busy_q[chk_rs1_i] | busy_q[chk_rs2_i] |
                            (iss_valid_i & busy_q[iss_rd_i]));
    assign busy_o  = rst ? busy_q : '0;

    // Issuing to a register that is still pending is a decode bug.
    a_no_issue_busy: assert property (@(posedge clk) disable iff (!rst)
        !(iss_valid_i && busy_q[iss_rd_i]));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and the multi-cycle unit.
// Latency: 0 cycles source-valid to write; a buffered result drains within STARVE_LIMIT+1 cycles.
// Backpressure: m_ready drops while the one-entry buffer is full; p_hold stalls the pipeline one cycle on starvation.
module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p_valid,
    input  logic [4:0]      p_wr,
    input  logic [XLEN-1:0] p_wd,
    output logic            p_hold,
    input  logic            m_valid,
    input  logic [4:0]      m_wr,
    input  logic [XLEN-1:0] m_wd,
    output logic            m_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    output logic            stall,
    output logic            RFWr,
    output logic [31:0]     wR,
    output logic [XLEN-1:0] wD,
    output logic [31:0]     busy
);
    import rf_ctrl_pkg::*;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wr;
        logic [XLEN-1:0]   wd;
    } buf_t;

    buf_t              buf_q, buf_d;
    logic [3:0]        age_q, age_d;
    logic              p_hold_q, p_hold_d;
    gnt_e              gnt;
    logic [REG_AW-1:0] gnt_wr;
    logic [XLEN-1:0]   gnt_wd;
    logic              m_acc;
    logic              buf_lost;
    logic [3:0]        age_inc;

    // Grant priority: forced drain, pipeline, buffer, then direct multi-cycle bypass.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst)             gnt = GNT_NONE;
        else if (p_hold_q)    gnt = buf_q.valid ? GNT_BUF : GNT_NONE;
        else if (p_valid)     gnt = GNT_PIPE;
        else if (buf_q.valid) gnt = GNT_BUF;
        else if (m_valid)     gnt = GNT_MDIR;
    end

    // Write-port mux; x0 targets are consumed without a write strobe.
    always_comb begin
        gnt_wr = '0;
        gnt_wd = '0;
        case (gnt)
            GNT_PIPE: begin gnt_wr = p_wr;     gnt_wd = p_wd;     end
            GNT_BUF:  begin gnt_wr = buf_q.wr; gnt_wd = buf_q.wd; end
            GNT_MDIR: begin gnt_wr = m_wr;     gnt_wd = m_wd;     end
            default:  begin gnt_wr = '0;       gnt_wd = '0;       end
        endcase
    end

    assign RFWr    = (gnt != GNT_NONE) && (gnt_wr != '0);
    assign wR      = {{(32-REG_AW){1'b0}}, gnt_wr};
    assign wD      = gnt_wd;
    assign m_ready = rst & ~buf_q.valid;
    assign m_acc   = m_valid & m_ready;
    assign p_hold  = rst & p_hold_q;

    // A buffered result that loses arbitration ages; reaching the limit forces one hold cycle.
    assign buf_lost = buf_q.valid && (gnt != GNT_BUF);
    assign age_inc  = age_q + 4'd1;

    // Buffer drains when granted and captures an accepted result that was not bypassed.
    always_comb begin
        buf_d    = buf_q;
        age_d    = buf_lost ? age_inc : 4'd0;
        p_hold_d = buf_lost && (age_inc == LIMIT);
        if (gnt == GNT_BUF) buf_d.valid = 1'b0;
        if (m_acc && (gnt != GNT_MDIR)) begin
            buf_d.valid = 1'b1;
            buf_d.wr    = m_wr;
            buf_d.wd    = m_wd;
        end
    end

    // Arbitration state with synchronous active-low reset; reset discards the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q    <= '0;
            age_q    <= '0;
            p_hold_q <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            age_q    <= age_d;
            p_hold_q <= p_hold_d;
        end
    end

    rf_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .iss_valid_i (iss_valid & (iss_rd != '0)),
        .iss_rd_i    (iss_rd),
        .clr_valid_i ((gnt == GNT_BUF) || (gnt == GNT_MDIR)),
        .clr_rd_i    (gnt_wr),
        .chk_rs1_i   (chk_rs1),
        .chk_rs2_i   (chk_rs2),
        .stall_o     (stall),
        .busy_o      (busy)
    );

    // The pipeline must honour the hold; a write presented during it is lost.
    a_no_pvalid_in_hold: assert property (@(posedge clk) disable iff (!rst)
        !(p_valid && p_hold_q));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid, m_valid, iss_valid;
    logic [4:0]  p_wr, m_wr, iss_rd, chk_rs1, chk_rs2;
    logic [31:0] p_wd, m_wd;
    logic        p_hold, m_ready, stall, RFWr;
    logic [31:0] wR, wD, busy;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_wr(p_wr), .p_wd(p_wd), .p_hold(p_hold),
        .m_valid(m_valid), .m_wr(m_wr), .m_wd(m_wd), .m_ready(m_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .stall(stall),
        .RFWr(RFWr), .wR(wR), .wD(wD), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clr_in;
        p_valid = 0; p_wr = 0; p_wd = 0;
        m_valid = 0; m_wr = 0; m_wd = 0;
        iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    endtask

    task automatic set_pm(input logic pv, input logic [4:0] pwr, input logic [31:0] pwd,
                          input logic mv, input logic [4:0] mwr, input logic [31:0] mwd);
        p_valid = pv; p_wr = pwr; p_wd = pwd;
        m_valid = mv; m_wr = mwr; m_wd = mwd;
    endtask

    task automatic do_reset;
        tick;
        clr_in();
        rst = 0;
        #1;
        chk("rst_rfwr", {31'b0, RFWr}, 0);
        chk("rst_mready", {31'b0, m_ready}, 0);
        chk("rst_phold", {31'b0, p_hold}, 0);
        chk("rst_busy", busy, 0);
        tick;
        rst = 1;
    endtask

    typedef struct {
        logic        pv;
        logic [4:0]  pwr;
        logic [31:0] pwd;
        logic        mv;
        logic [4:0]  mwr;
        logic [31:0] mwd;
        logic        e_rfwr;
        logic [31:0] e_wr;
        logic [31:0] e_wd;
        logic        e_mrdy;
    } vec_t;

    vec_t vecs[6];

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] wd;
        int          cap;
    } ent_t;

    initial begin
        // Model state for the randomized phase.
        ent_t        q[$];
        int          age;
        bit          mh;
        logic [31:0] mb;
        int          src;
        logic [4:0]  d;
        logic [31:0] v;
        logic        e_rfwr, e_mrdy, e_stall, had;
        logic [31:0] e_wr, e_wd;
        int          r;

        rst = 0;
        clr_in();

        // Single-cycle vectors from an empty state.
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 32'd5, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 32'd0, 32'h0,        1'b1};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11, 1'b1, 32'd7, 32'h11,       1'b1};
        vecs[3] = '{1'b1, 5'd3, 32'hAA,       1'b1, 5'd7, 32'h11, 1'b1, 32'd3, 32'hAA,       1'b1};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55, 1'b0, 32'd0, 32'h55,       1'b1};
        vecs[5] = '{1'b1, 5'd0, 32'h66,       1'b0, 5'd0, 32'h0,  1'b0, 32'd0, 32'h66,       1'b1};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            tick;
            set_pm(vecs[i].pv, vecs[i].pwr, vecs[i].pwd, vecs[i].mv, vecs[i].mwr, vecs[i].mwd);
            #1;
            chk($sformatf("vec%0d_rfwr", i), {31'b0, RFWr}, {31'b0, vecs[i].e_rfwr});
            chk($sformatf("vec%0d_wr", i), wR, vecs[i].e_wr);
            chk($sformatf("vec%0d_wd", i), wD, vecs[i].e_wd);
            chk($sformatf("vec%0d_mrdy", i), {31'b0, m_ready}, {31'b0, vecs[i].e_mrdy});
        end

        // Collision: pipeline wins, m result buffered then written when pipeline idles.
        do_reset();
        tick; set_pm(1, 5'd3, 32'h33, 1, 5'd7, 32'h11); #1;
        chk("col_pipe_wr", wR, 3);
        tick; set_pm(1, 5'd4, 32'h44, 0, 0, 0); #1;
        chk("col_mready_full", {31'b0, m_ready}, 0);
        chk("col_pipe2_wr", wR, 4);
        tick; set_pm(0, 0, 0, 0, 0, 0); #1;
        chk("col_buf_rfwr", {31'b0, RFWr}, 1);
        chk("col_buf_wr", wR, 7);
        chk("col_buf_wd", wD, 32'h11);
        tick; #1;
        chk("col_mready_free", {31'b0, m_ready}, 1);
        chk("col_idle_rfwr", {31'b0, RFWr}, 0);

        // Starvation: two rounds show the age count restarts after the forced drain.
        do_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            tick; set_pm(1, 5'd1, 32'h100 + rnd, 1, 5'd12, 32'hC0DE0 + rnd); #1;
            chk("stv_cap_wr", wR, 1);
            for (int k = 1; k <= LIMIT; k++) begin
                tick; set_pm(1, 5'd2, 32'h200 + k, 0, 0, 0); #1;
                chk($sformatf("stv_nohold_c%0d", k), {31'b0, p_hold}, 0);
                chk($sformatf("stv_pipe_c%0d", k), wR, 2);
            end
            tick; set_pm(0, 0, 0, 0, 0, 0); #1;
            chk("stv_hold", {31'b0, p_hold}, 1);
            chk("stv_drain_wr", wR, 12);
            chk("stv_drain_wd", wD, 32'hC0DE0 + rnd);
            chk("stv_drain_rfwr", {31'b0, RFWr}, 1);
            tick; #1;
            chk("stv_hold_off", {31'b0, p_hold}, 0);
            chk("stv_mready", {31'b0, m_ready}, 1);
        end

        // Scoreboard: issue r9, stall until the cycle after its m write.
        do_reset();
        tick; iss_valid = 1; iss_rd = 9; chk_rs1 = 9; #1;
        chk("sb_issue_stall", {31'b0, stall}, 0);
        for (int k = 0; k < 3; k++) begin
            tick; iss_valid = 0; iss_rd = 0; #1;
            chk("sb_stall_pend", {31'b0, stall}, 1);
            chk("sb_busy_pend", busy, 32'h0000_0200);
        end
        tick; set_pm(0, 0, 0, 1, 5'd9, 32'h99); #1;
        chk("sb_mwrite_wr", wR, 9);
        chk("sb_stall_wr_cycle", {31'b0, stall}, 1);
        tick; set_pm(0, 0, 0, 0, 0, 0); #1;
        chk("sb_stall_clear", {31'b0, stall}, 0);
        chk("sb_busy_clear", busy, 0);
        tick; chk_rs1 = 0; chk_rs2 = 9; iss_valid = 1; iss_rd = 9; #1;
        chk("sb_issue_again", {31'b0, stall}, 0);
        tick; iss_valid = 0; #1;
        chk("sb_rs2_stall", {31'b0, stall}, 1);

        // x0 results and x0 issue never touch the scoreboard.
        tick; chk_rs2 = 0; set_pm(0, 0, 0, 1, 5'd0, 32'h77); #1;
        chk("x0_mready", {31'b0, m_ready}, 1);
        chk("x0_rfwr", {31'b0, RFWr}, 0);
        tick; set_pm(0, 0, 0, 0, 0, 0); iss_valid = 1; iss_rd = 0; #1;
        chk("x0_busy_kept", busy, 32'h0000_0200);
        tick; iss_valid = 0; #1;
        chk("x0_issue_busy", busy, 32'h0000_0200);

        // Reset mid-operation drops the buffer and the busy bits.
        do_reset();
        tick; iss_valid = 1; iss_rd = 9; #1;
        tick; iss_valid = 0; set_pm(1, 5'd2, 32'h22, 1, 5'd9, 32'h9999); #1;
        tick; set_pm(0, 0, 0, 0, 0, 0); chk_rs1 = 9; #1;
        chk("mid_busy_before", busy, 32'h0000_0200);
        tick; rst = 0; #1;
        chk("mid_rst_rfwr", {31'b0, RFWr}, 0);
        chk("mid_rst_mready", {31'b0, m_ready}, 0);
        chk("mid_rst_stall", {31'b0, stall}, 0);
        chk("mid_rst_busy", busy, 0);
        tick; rst = 1; #1;
        chk("mid_after_busy", busy, 0);
        chk("mid_after_mready", {31'b0, m_ready}, 1);
        for (int k = 0; k < 6; k++) begin
            tick; #1;
            chk($sformatf("mid_no_ghost_%0d", k), {31'b0, RFWr}, 0);
        end

        // Randomized traffic against a queue-based reference model.
        do_reset();
        q.delete(); age = 0; mh = 0; mb = '0;
        for (int c = 0; c < 3000; c++) begin
            tick;
            rst       = ($urandom_range(0, 63) != 0);
            p_valid   = !mh && ($urandom_range(0, 9) < 6);
            p_wr      = 5'($urandom_range(0, 31));
            p_wd      = $urandom;
            m_valid   = ($urandom_range(0, 1) == 1);
            m_wr      = 5'($urandom_range(0, 31));
            m_wd      = $urandom;
            chk_rs1   = 5'($urandom_range(0, 31));
            chk_rs2   = 5'($urandom_range(0, 31));
            r         = $urandom_range(0, 31);
            iss_rd    = 5'(r);
            iss_valid = ($urandom_range(0, 3) == 0) && !mb[r];
            #1;
            src = 0; d = 0; v = 0;
            if (rst) begin
                if (mh)                 src = (q.size() != 0) ? 2 : 0;
                else if (p_valid)       src = 1;
                else if (q.size() != 0) src = 2;
                else if (m_valid)       src = 3;
            end
            case (src)
                1: begin d = p_wr;    v = p_wd;    end
                2: begin d = q[0].wr; v = q[0].wd; end
                3: begin d = m_wr;    v = m_wd;    end
                default: begin d = 0; v = 0; end
            endcase
            e_rfwr  = (src != 0) && (d != 0);
            e_wr    = {27'b0, d};
            e_wd    = v;
            e_mrdy  = rst && (q.size() == 0);
            e_stall = rst && (mb[chk_rs1] || mb[chk_rs2] || (iss_valid && mb[iss_rd]));
            chk("rnd_rfwr", {31'b0, RFWr}, {31'b0, e_rfwr});
            chk("rnd_wr", wR, e_wr);
            chk("rnd_wd", wD, e_wd);
            chk("rnd_mready", {31'b0, m_ready}, {31'b0, e_mrdy});
            chk("rnd_stall", {31'b0, stall}, {31'b0, e_stall});
            chk("rnd_phold", {31'b0, p_hold}, rst ? {31'b0, mh} : 32'd0);
            chk("rnd_busy", busy, rst ? mb : 32'd0);
            if (!rst) begin
                q.delete(); age = 0; mh = 0; mb = '0;
            end else begin
                had = (q.size() != 0);
                if (src == 2) begin
                    chk("rnd_buf_latency", {31'b0, (c - q[0].cap) <= LIMIT + 1}, 1);
                    void'(q.pop_front());
                    age = 0;
                end else if (had) begin
                    age++;
                end else begin
                    age = 0;
                end
                mh = had && (src != 2) && (age == LIMIT);
                if (m_valid && e_mrdy && src != 3) q.push_back('{m_wr, m_wd, c});
                if (src == 2 || src == 3) mb[d] = 1'b0;
                if (iss_valid && iss_rd != 0) mb[iss_rd] = 1'b1;
                mb[0] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
